decode_imm_stage: RTL and testbench
===================================

# decode_imm_stage

Registered, flow-controlled immediate-generation stage for the decode pipeline. Accepts one 32-bit instruction word plus its PC per handshake. Emits, one cycle later, the sign-extended XLEN-wide immediate, the link value (pc + 4), the instruction format and an illegal flag. Supports RV32 and RV64 (shift-amount and word-op immediates included), and provides full-throughput backpressure through a two-entry skid buffer. Sits between fetch/instruction-buffer and the register-read stage.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_link  out  XLEN  in_pc + 4, modulo 2^XLEN.
- out_fmt  out  3  imm_fmt_e: NONE, I, S, B, U, J, SHAMT.
- out_illegal  out  1  opcode not recognised for this XLEN.

## Operation
- Immediates are extended by replicating instr[31] to XLEN bits. Decode is per opcode:
  - LUI and AUIPC produce U: {instr[31:12], 12'b0}, sign-extended (RV64: bit 31 fills the upper 32 bits).
  - JAL produces J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - JALR, LOAD and SYSTEM produce I: instr[31:20].
  - BRANCH produces B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - STORE produces S: {instr[31:25], instr[11:7]}.
  - OP-IMM with funct3 other than 001/101 produces I.
  - OP-IMM with funct3 001/101 produces SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; instr[30] is excluded.
  - OP-IMM-32 (0011011) is legal only when XLEN=64: I, or SHAMT of instr[24:20] for funct3 001/101.
- Any other opcode, or instr[1:0] != 2'b11, gives fmt NONE, imm 0 and illegal 1. Illegal words are still passed downstream.
- JAL and JALR carry the real offset on out_imm; the link value travels separately on out_link.
- Skid buffer has three states:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on output handshake with no accept.
  - ONE → TWO on accept with no output handshake.
  - TWO → ONE on output handshake (no accept is possible in TWO).
  - Accept and output handshake in the same cycle while in ONE: stays ONE, the head is replaced by the new entry.
- Ordering is strict FIFO.
- flush has priority: next state is EMPTY, and any input handshake in the same cycle is discarded.

## Timing
- Reset values: out_valid 0, in_ready 1, out_imm 0, out_link 0, out_fmt NONE, out_illegal 0, state EMPTY.
- Latency: accept at edge N gives out_valid high after edge N, so the result is visible in the cycle following acceptance.
- Throughput: one word per cycle while out_ready is held high.
- in_ready = (state != TWO). It is a register-derived value with no combinational path from out_ready.
- out_* hold stable while out_valid && !out_ready.
- Reset asserted mid-operation drops all entries immediately; outputs go to their reset values without waiting for a clock edge.
- Decode is combinational on the input side; the result is registered on accept. Worst path is the opcode mux plus the pc+4 adder.

## Structure
- Package decode_pkg holds:
  - opcode localparams: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_IMM_32, SYSTEM;
  - typedef enum logic [2:0] imm_fmt_e;
  - a packed struct imm_entry_t {imm, link, fmt, illegal}, parametrised through XLEN at the use site.
- Sub-module imm_decode: purely combinational, maps (instr, pc) to imm_entry_t. The top holds the two-entry skid buffer and state register.

## Test plan
- XLEN=32. ADDI 0xFFF00093, pc 0x0: one cycle later out_imm 0xFFFFFFFF, fmt I, link 0x4, illegal 0.
- XLEN=32. BEQ 0xFE000EE3: out_imm 0xFFFFFFFC, fmt B. JAL 0x0080006F with pc 0x100: out_imm 0x8, link 0x104, fmt J.
- XLEN=64. LUI 0x800000B7: out_imm 0xFFFFFFFF80000000. SRAI x1,x1,33 (0x4210D093): out_imm 0x21, fmt SHAMT.
- XLEN=32. OP-IMM-32 word 0x0010809B: illegal 1, fmt NONE, imm 0. Under XLEN=64 the same word gives imm 1, fmt I.
- Backpressure: out_ready held low, three back-to-back valid inputs. The first two are accepted and in_ready drops after the second. Raise out_ready: outputs appear in order with no loss or duplication, and the third input is then accepted.
- Two entries held, then flush asserted together with in_valid: next cycle out_valid 0 and in_ready 1, with nothing emitted. Repeat with rst_n pulsed low mid-stream: outputs go to reset values asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: base opcodes, immediate format encoding and the
// state encoding of the two-entry output skid buffer.
package decode_pkg;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SHAMT
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_e;

    // SLLI/SRLI/SRAI share OP-IMM with the arithmetic immediates; only funct3 tells them apart.
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/decode_imm_decode.sv
// Combinational immediate generator: maps one instruction word and its PC to
// the extended immediate, link value, format tag and illegal flag.
module imm_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] link,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] shamt_op;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    // instr[25] only widens the shift amount on RV64; instr[30] selects SRAI and is never part of it.
    assign shamt_op = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    assign link     = pc + XLEN'(4);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                LUI, AUIPC: begin
                    fmt = FMT_U;
                    imm = sext32({instr[31:12], 12'b0});
                end
                JAL: begin
                    fmt = FMT_J;
                    imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
                end
                JALR, LOAD, SYSTEM: begin
                    fmt = FMT_I;
                    imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
                BRANCH: begin
                    fmt = FMT_B;
                    imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
                end
                STORE: begin
                    fmt = FMT_S;
                    imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
                end
                OP_IMM: begin
                    if (is_shift(funct3)) begin
                        fmt = FMT_SHAMT;
                        imm = XLEN'(shamt_op);
                    end else begin
                        fmt = FMT_I;
                        imm = sext32({{20{instr[31]}}, instr[31:20]});
                    end
                end
                OP_IMM_32: begin
                    if (XLEN != 64) begin
                        illegal = 1'b1;
                    end else if (is_shift(funct3)) begin
                        fmt = FMT_SHAMT;
                        imm = XLEN'(instr[24:20]);
                    end else begin
                        fmt = FMT_I;
                        imm = sext32({{20{instr[31]}}, instr[31:20]});
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Registered immediate-generation stage: decodes on the input side, then holds
// results in a two-entry skid buffer so in_ready never depends on out_ready.
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_link,
    output imm_fmt_e        out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] link;
        imm_fmt_e        fmt;
        logic            illegal;
    } imm_entry_t;

    imm_entry_t  dec_p0;
    imm_entry_t  head_p1;
    imm_entry_t  tail_p1;
    skid_state_e state;
    skid_state_e state_d;
    logic        accept;
    logic        deq;
    logic        head_load;
    logic        head_from_tail;
    logic        tail_load;

    // p0: combinational decode of the word being offered
    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .instr   (in_instr),
        .pc      (in_pc),
        .imm     (dec_p0.imm),
        .link    (dec_p0.link),
        .fmt     (dec_p0.fmt),
        .illegal (dec_p0.illegal)
    );

    assign accept = in_valid && in_ready;
    assign deq    = out_valid && out_ready;

    always_comb begin
        state_d        = state;
        head_load      = 1'b0;
        head_from_tail = 1'b0;
        tail_load      = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d   = SKID_ONE;
                        head_load = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && deq) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_d   = SKID_TWO;
                        tail_load = 1'b1;
                    end else if (deq) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (deq) begin
                        state_d        = SKID_ONE;
                        head_from_tail = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // p1: head entry drives the outputs, so it alone carries reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            head_p1   <= '0;
        end else begin
            state     <= state_d;
            out_valid <= (state_d != SKID_EMPTY);
            in_ready  <= (state_d != SKID_TWO);
            if (head_from_tail) begin
                head_p1 <= tail_p1;
            end else if (head_load) begin
                head_p1 <= dec_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tail_load) begin
            tail_p1 <= dec_p0;
        end
    end

    assign out_imm     = head_p1.imm;
    assign out_link    = head_p1.link;
    assign out_fmt     = head_p1.fmt;
    assign out_illegal = head_p1.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: RV32 and RV64 instances share one input stream and
// are compared against an arithmetic reference decoder and a FIFO occupancy model.
module tb_decode_imm_stage;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_I     = 3'd1;
    localparam logic [2:0] F_S     = 3'd2;
    localparam logic [2:0] F_B     = 3'd3;
    localparam logic [2:0] F_U     = 3'd4;
    localparam logic [2:0] F_J     = 3'd5;
    localparam logic [2:0] F_SHAMT = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] pc64 = 64'h0;

    logic        rdy32, vld32, ill32;
    logic        rdy64, vld64, ill64;
    logic [31:0] imm32, link32;
    logic [63:0] imm64, link64;
    logic [2:0]  fmt32, fmt64;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
    } txn_t;
    txn_t q[$];

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
        int          xlen;
        logic [63:0] imm;
        logic [63:0] link;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    always #5 clk = ~clk;

    decode_imm_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_link(link32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    decode_imm_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_link(link64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    // Reference decoder: immediates as weighted bit sums, MSB weight negative.
    function automatic void ref_dec(input logic [31:0] w, input logic [63:0] pc, input int xlen,
                                    output logic [63:0] imm, output logic [63:0] link,
                                    output logic [2:0] fmt, output logic ill);
        longint     v;
        logic [2:0] f3;
        bit         shift;
        logic [63:0] l;
        f3    = w[14:12];
        shift = (f3 == 3'b001) || (f3 == 3'b101);
        v     = 0;
        fmt   = F_NONE;
        ill   = 1'b0;
        case (w[6:0])
            7'h37, 7'h17: begin
                fmt = F_U;
                v = longint'(w[30:12]) * 4096;
                if (w[31]) v -= 64'sd2147483648;
            end
            7'h6F: begin
                fmt = F_J;
                v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (w[31]) v -= 1048576;
            end
            7'h67, 7'h03, 7'h73: begin
                fmt = F_I;
                v = longint'(w[30:20]);
                if (w[31]) v -= 2048;
            end
            7'h63: begin
                fmt = F_B;
                v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (w[31]) v -= 4096;
            end
            7'h23: begin
                fmt = F_S;
                v = longint'(w[30:25]) * 32 + longint'(w[11:7]);
                if (w[31]) v -= 2048;
            end
            7'h13: begin
                if (shift) begin
                    fmt = F_SHAMT;
                    v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
                end else begin
                    fmt = F_I;
                    v = longint'(w[30:20]);
                    if (w[31]) v -= 2048;
                end
            end
            7'h1B: begin
                if (xlen != 64) begin
                    ill = 1'b1;
                end else if (shift) begin
                    fmt = F_SHAMT;
                    v = longint'(w[24:20]);
                end else begin
                    fmt = F_I;
                    v = longint'(w[30:20]);
                    if (w[31]) v -= 2048;
                end
            end
            default: ill = 1'b1;
        endcase
        imm = v;
        l   = pc + 64'd4;
        if (xlen == 32) begin
            imm  = {32'h0, imm[31:0]};
            l    = {32'h0, l[31:0]};
        end
        link = l;
    endfunction

    // Applies one cycle of inputs and advances the occupancy model; returns at the next negedge.
    task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        bit   acc, dq;
        txn_t t;
        in_valid  = v;
        in_instr  = w;
        pc64      = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        acc = v && (q.size() < 2);
        dq  = (q.size() > 0) && rdy;
        if (fl) begin
            q.delete();
        end else begin
            if (dq) void'(q.pop_front());
            if (acc) begin
                t.w  = w;
                t.pc = pc;
                q.push_back(t);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vld32, rdy32, imm32, link32, fmt32, ill32} !== {1'b0, 1'b1, 32'h0, 32'h0, F_NONE, 1'b0}) begin
            n_fail++;
            $display("FAIL reset32 got v=%b r=%b imm=%h link=%h fmt=%0d ill=%b required v=0 r=1 imm=0 link=0 fmt=0 ill=0",
                     vld32, rdy32, imm32, link32, fmt32, ill32);
        end
        n_checks++;
        if ({vld64, rdy64, imm64, link64, fmt64, ill64} !== {1'b0, 1'b1, 64'h0, 64'h0, F_NONE, 1'b0}) begin
            n_fail++;
            $display("FAIL reset64 got v=%b r=%b imm=%h link=%h fmt=%0d ill=%b required v=0 r=1 imm=0 link=0 fmt=0 ill=0",
                     vld64, rdy64, imm64, link64, fmt64, ill64);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_release got v32=%b r32=%b v64=%b r64=%b required 0 1 0 1", vld32, rdy32, vld64, rdy64);
        end
    endtask

    task automatic test_vectors();
        vec_t        vecs [13];
        logic        gv;
        logic [63:0] gimm, glink;
        logic [2:0]  gfmt;
        logic        gill;
        vecs[0]  = '{32'hFFF00093, 64'h0,    32, 64'hFFFFFFFF,         64'h4,    F_I,     1'b0};
        vecs[1]  = '{32'hFE000EE3, 64'h40,   32, 64'hFFFFFFFC,         64'h44,   F_B,     1'b0};
        vecs[2]  = '{32'h0080006F, 64'h100,  32, 64'h8,                64'h104,  F_J,     1'b0};
        vecs[3]  = '{32'h800000B7, 64'h1000, 64, 64'hFFFFFFFF80000000, 64'h1004, F_U,     1'b0};
        vecs[4]  = '{32'h4210D093, 64'h2000, 64, 64'h21,               64'h2004, F_SHAMT, 1'b0};
        vecs[5]  = '{32'h4210D093, 64'h2000, 32, 64'h1,                64'h2004, F_SHAMT, 1'b0};
        vecs[6]  = '{32'h0010809B, 64'h8,    32, 64'h0,                64'hC,    F_NONE,  1'b1};
        vecs[7]  = '{32'h0010809B, 64'h8,    64, 64'h1,                64'hC,    F_I,     1'b0};
        vecs[8]  = '{32'h00000010, 64'hFFFFFFFFFFFFFFFC, 32, 64'h0,    64'h0,    F_NONE,  1'b1};
        vecs[9]  = '{32'h00000010, 64'hFFFFFFFFFFFFFFFC, 64, 64'h0,    64'h0,    F_NONE,  1'b1};
        vecs[10] = '{32'hFE112E23, 64'h20,   64, 64'hFFFFFFFFFFFFFFFC, 64'h24,   F_S,     1'b0};
        vecs[11] = '{32'h800080E7, 64'h10,   32, 64'hFFFFF800,         64'h14,   F_I,     1'b0};
        vecs[12] = '{32'h12345097, 64'h30,   64, 64'h12345000,         64'h34,   F_U,     1'b0};
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].w, vecs[i].pc, 1'b1, 1'b0);
            if (vecs[i].xlen == 32) begin
                gv = vld32; gimm = {32'h0, imm32}; glink = {32'h0, link32}; gfmt = fmt32; gill = ill32;
            end else begin
                gv = vld64; gimm = imm64; glink = link64; gfmt = fmt64; gill = ill64;
            end
            n_checks++;
            if ({gv, gimm, glink, gfmt, gill} !== {1'b1, vecs[i].imm, vecs[i].link, vecs[i].fmt, vecs[i].ill}) begin
                n_fail++;
                $display("FAIL vector%0d xlen=%0d got v=%b imm=%h link=%h fmt=%0d ill=%b required v=1 imm=%h link=%h fmt=%0d ill=%b",
                         i, vecs[i].xlen, gv, gimm, glink, gfmt, gill,
                         vecs[i].imm, vecs[i].link, vecs[i].fmt, vecs[i].ill);
            end
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int         wk [6] = '{1, 2, 3, 3, 3, 3};
        int         ek [6] = '{1, 1, 1, 2, 3, 0};
        logic [5:0] sv = 6'b011111;
        logic [5:0] sr = 6'b111000;
        logic [5:0] ev = 6'b011111;
        logic [5:0] er = 6'b111001;
        logic [31:0] w;
        for (int i = 0; i < 6; i++) begin
            w = (32'(wk[i]) << 20) | 32'h00000093;
            drive(sv[i], w, 64'h400 + 64'(4 * i), sr[i], 1'b0);
            n_checks++;
            if ({vld32, rdy32, (vld32 ? imm32 : 32'h0)} !== {ev[i], er[i], (ev[i] ? 32'(ek[i]) : 32'h0)}) begin
                n_fail++;
                $display("FAIL backpressure32 step%0d got v=%b r=%b imm=%h required v=%b r=%b imm=%0d",
                         i, vld32, rdy32, imm32, ev[i], er[i], ek[i]);
            end
            n_checks++;
            if ({vld64, rdy64, (vld64 ? imm64 : 64'h0)} !== {ev[i], er[i], (ev[i] ? 64'(ek[i]) : 64'h0)}) begin
                n_fail++;
                $display("FAIL backpressure64 step%0d got v=%b r=%b imm=%h required v=%b r=%b imm=%0d",
                         i, vld64, rdy64, imm64, ev[i], er[i], ek[i]);
            end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00100093, 64'h500, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 64'h504, 1'b0, 1'b0);
        n_checks++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b1010) begin
            n_fail++;
            $display("FAIL flush_fill got v32=%b r32=%b v64=%b r64=%b required 1 0 1 0", vld32, rdy32, vld64, rdy64);
        end
        drive(1'b1, 32'h00300093, 64'h508, 1'b1, 1'b1);
        n_checks++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b0101) begin
            n_fail++;
            $display("FAIL flush_kill got v32=%b r32=%b v64=%b r64=%b required 0 1 0 1", vld32, rdy32, vld64, rdy64);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if ({vld32, vld64} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_after got v32=%b v64=%b required 0 0", vld32, vld64);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hFFF00093, 64'h600, 1'b0, 1'b0);
        drive(1'b1, 32'h800000B7, 64'h604, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vld32, rdy32, imm32, link32, fmt32, ill32} !== {1'b0, 1'b1, 32'h0, 32'h0, F_NONE, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset32 got v=%b r=%b imm=%h link=%h fmt=%0d ill=%b required all reset values",
                     vld32, rdy32, imm32, link32, fmt32, ill32);
        end
        n_checks++;
        if ({vld64, rdy64, imm64, link64, fmt64, ill64} !== {1'b0, 1'b1, 64'h0, 64'h0, F_NONE, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset64 got v=%b r=%b imm=%h link=%h fmt=%0d ill=%b required all reset values",
                     vld64, rdy64, imm64, link64, fmt64, ill64);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h00500093, 64'h700, 1'b1, 1'b0);
        n_checks++;
        if ({vld32, imm32, link32, vld64, imm64} !== {1'b1, 32'h5, 32'h704, 1'b1, 64'h5}) begin
            n_fail++;
            $display("FAIL async_recover got v32=%b imm32=%h link32=%h v64=%b imm64=%h required 1 5 704 1 5",
                     vld32, imm32, link32, vld64, imm64);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] w;
        logic [63:0] e_imm, e_link;
        logic [2:0]  e_fmt;
        logic        e_ill;
        int          sel;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h73, 7'h33};
        for (int c = 0; c < 400; c++) begin
            w   = $urandom;
            sel = $urandom_range(0, 12);
            if (sel < 11) w[6:0] = ops[sel];
            drive(($urandom_range(0, 3) != 0), w, {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            n_checks++;
            if ({vld32, rdy32, vld64, rdy64} !== {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d got v32=%b r32=%b v64=%b r64=%b required occupancy %0d",
                         c, vld32, rdy32, vld64, rdy64, q.size());
            end
            if (q.size() > 0) begin
                ref_dec(q[0].w, q[0].pc, 32, e_imm, e_link, e_fmt, e_ill);
                n_checks++;
                if ({imm32, link32, fmt32, ill32} !== {e_imm[31:0], e_link[31:0], e_fmt, e_ill}) begin
                    n_fail++;
                    $display("FAIL rand_data32 cyc=%0d instr=%h got imm=%h link=%h fmt=%0d ill=%b required imm=%h link=%h fmt=%0d ill=%b",
                             c, q[0].w, imm32, link32, fmt32, ill32, e_imm[31:0], e_link[31:0], e_fmt, e_ill);
                end
                ref_dec(q[0].w, q[0].pc, 64, e_imm, e_link, e_fmt, e_ill);
                n_checks++;
                if ({imm64, link64, fmt64, ill64} !== {e_imm, e_link, e_fmt, e_ill}) begin
                    n_fail++;
                    $display("FAIL rand_data64 cyc=%0d instr=%h got imm=%h link=%h fmt=%0d ill=%b required imm=%h link=%h fmt=%0d ill=%b",
                             c, q[0].w, imm64, link64, fmt64, ill64, e_imm, e_link, e_fmt, e_ill);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
